// File: rtl/nlfsr_tester_dispatcher_if.sv
// Handshake bundle between the NLFSR candidate generator, the tester slots,
// the result consumer and the dispatcher.
interface nlfsr_tester_dispatcher_if #(
  parameter int unsigned NUM_TESTERS = 4,
  parameter int unsigned CAND_WIDTH  = 64
) ();
  logic [CAND_WIDTH-1:0]  cand_data;
  logic                   cand_valid;
  logic                   cand_ready;
  logic [CAND_WIDTH-1:0]  tst_cand;
  logic [NUM_TESTERS-1:0] tst_start;
  logic [NUM_TESTERS-1:0] tst_done;
  logic [NUM_TESTERS-1:0] tst_pass;
  logic [CAND_WIDTH-1:0]  res_data;
  logic                   res_valid;
  logic                   res_ready;

  // Dispatcher side
  modport slave (
    input  cand_data, cand_valid, tst_done, tst_pass, res_ready,
    output cand_ready, tst_cand, tst_start, res_data, res_valid
  );

  // Generator / tester / consumer side
  modport master (
    output cand_data, cand_valid, tst_done, tst_pass, res_ready,
    input  cand_ready, tst_cand, tst_start, res_data, res_valid
  );
endinterface

// File: rtl/nlfsr_tester_dispatcher.sv
// Dispatches NLFSR candidates round-robin to tester slots and forwards the
// candidates whose testers report a maximal period, one at a time.
module nlfsr_tester_dispatcher #(
  parameter int unsigned NUM_TESTERS = 4,
  parameter int unsigned CAND_WIDTH  = 64
) (
  input  logic                     clk_fast,
  input  logic                     reset,
  input  logic                     enable,
  nlfsr_tester_dispatcher_if.slave bus,
  output logic [31:0]              cnt_dispatched,
  output logic [15:0]              cnt_found,
  output logic                     idle
);

  localparam int unsigned IW = (NUM_TESTERS > 1) ? $clog2(NUM_TESTERS) : 1;

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_RUNNING,
    SLOT_REPORT
  } slot_st_t;

  typedef enum logic {
    RES_EMPTY,
    RES_HOLD
  } res_st_t;

  slot_st_t              r_slot_st   [NUM_TESTERS];
  slot_st_t              w_slot_nxt  [NUM_TESTERS];
  logic [CAND_WIDTH-1:0] r_slot_cand [NUM_TESTERS];

  res_st_t                r_res_st;
  res_st_t                w_res_nxt;
  logic [IW-1:0]          r_res_idx;
  logic [CAND_WIDTH-1:0]  r_res_data;

  logic [IW-1:0]          r_rr_disp;
  logic [IW-1:0]          r_rr_rep;
  logic [NUM_TESTERS-1:0] r_tst_start;
  logic [CAND_WIDTH-1:0]  r_tst_cand;
  logic [31:0]            r_cnt_disp;
  logic [15:0]            r_cnt_found;

  logic                   w_disp_found;
  logic [IW-1:0]          w_disp_idx;
  logic                   w_rep_found;
  logic [IW-1:0]          w_rep_idx;
  logic                   w_any_busy;
  logic                   w_cand_ready;
  logic                   w_accept;
  logic                   w_load;
  logic                   w_release;
  logic [NUM_TESTERS-1:0] w_start_onehot;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base,
                                             input int unsigned   off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_TESTERS) s = s - NUM_TESTERS;
    return IW'(s);
  endfunction

  // Round-robin searches: first FREE slot from r_rr_disp, first REPORT slot from r_rr_rep
  always_comb begin
    w_disp_found = 1'b0;
    w_disp_idx   = '0;
    w_rep_found  = 1'b0;
    w_rep_idx    = '0;
    w_any_busy   = 1'b0;
    for (int unsigned k = 0; k < NUM_TESTERS; k++) begin
      if (!w_disp_found && r_slot_st[wrap_idx(r_rr_disp, k)] == SLOT_FREE) begin
        w_disp_found = 1'b1;
        w_disp_idx   = wrap_idx(r_rr_disp, k);
      end
      if (!w_rep_found && r_slot_st[wrap_idx(r_rr_rep, k)] == SLOT_REPORT) begin
        w_rep_found = 1'b1;
        w_rep_idx   = wrap_idx(r_rr_rep, k);
      end
      if (r_slot_st[k] != SLOT_FREE) w_any_busy = 1'b1;
    end
  end

  assign w_cand_ready = enable & w_disp_found & ~reset;
  assign w_accept     = w_cand_ready & bus.cand_valid;

  always_comb begin
    w_start_onehot             = '0;
    w_start_onehot[w_disp_idx] = 1'b1;
  end

  // Result channel: EMPTY loads the next REPORT slot, HOLD waits for res_ready.
  // Leaving HOLD always passes through EMPTY, giving the one idle cycle between results.
  always_comb begin
    w_res_nxt = r_res_st;
    w_load    = 1'b0;
    w_release = 1'b0;
    case (r_res_st)
      RES_EMPTY: begin
        if (w_rep_found) begin
          w_load    = 1'b1;
          w_res_nxt = RES_HOLD;
        end
      end
      RES_HOLD: begin
        if (bus.res_ready) begin
          w_release = 1'b1;
          w_res_nxt = RES_EMPTY;
        end
      end
      default: w_res_nxt = RES_EMPTY;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_TESTERS; i++) begin
      w_slot_nxt[i] = r_slot_st[i];
      case (r_slot_st[i])
        SLOT_FREE: begin
          if (w_accept && w_disp_idx == IW'(i)) w_slot_nxt[i] = SLOT_RUNNING;
        end
        SLOT_RUNNING: begin
          if (bus.tst_done[i])
            w_slot_nxt[i] = bus.tst_pass[i] ? SLOT_REPORT : SLOT_FREE;
        end
        SLOT_REPORT: begin
          if (w_release && r_res_idx == IW'(i)) w_slot_nxt[i] = SLOT_FREE;
        end
        default: w_slot_nxt[i] = SLOT_FREE;
      endcase
    end
  end

  always_ff @(posedge clk_fast) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_TESTERS; i++) r_slot_st[i] <= SLOT_FREE;
      r_res_st    <= RES_EMPTY;
      r_res_idx   <= '0;
      r_res_data  <= '0;
      r_rr_disp   <= '0;
      r_rr_rep    <= '0;
      r_tst_start <= '0;
      r_tst_cand  <= '0;
      r_cnt_disp  <= '0;
      r_cnt_found <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_TESTERS; i++) r_slot_st[i] <= w_slot_nxt[i];
      r_res_st    <= w_res_nxt;
      r_tst_start <= '0;
      if (w_accept) begin
        r_tst_start <= w_start_onehot;
        r_tst_cand  <= bus.cand_data;
        r_rr_disp   <= wrap_idx(w_disp_idx, 1);
        r_cnt_disp  <= r_cnt_disp + 32'd1;
      end
      if (w_load) begin
        r_res_idx  <= w_rep_idx;
        r_res_data <= r_slot_cand[w_rep_idx];
      end
      if (w_release) begin
        r_rr_rep    <= wrap_idx(r_res_idx, 1);
        r_cnt_found <= r_cnt_found + 16'd1;
      end
    end
  end

  // Candidate storage is only meaningful while a slot is occupied, so it needs no reset
  always_ff @(posedge clk_fast) begin
    if (w_accept) r_slot_cand[w_disp_idx] <= bus.cand_data;
  end

  assign bus.cand_ready  = w_cand_ready;
  assign bus.tst_start   = r_tst_start;
  assign bus.tst_cand    = r_tst_cand;
  assign bus.res_valid   = (r_res_st == RES_HOLD);
  assign bus.res_data    = r_res_data;
  assign cnt_dispatched  = r_cnt_disp;
  assign cnt_found       = r_cnt_found;
  assign idle            = reset | (~w_any_busy & (r_res_st == RES_EMPTY));

endmodule

// File: tb/tb_nlfsr_tester_dispatcher.sv
// Bench for nlfsr_tester_dispatcher: directed scenarios followed by random
// traffic, all checked against a slot-level behavioural model.
module tb_nlfsr_tester_dispatcher;
  localparam int N = 4;
  localparam int W = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] cnt_d;
  logic [15:0] cnt_f;
  logic        idle;

  nlfsr_tester_dispatcher_if #(.NUM_TESTERS(N), .CAND_WIDTH(W)) bus ();

  nlfsr_tester_dispatcher #(.NUM_TESTERS(N), .CAND_WIDTH(W)) dut (
    .clk_fast       (clk),
    .reset          (rst),
    .enable         (en),
    .bus            (bus),
    .cnt_dispatched (cnt_d),
    .cnt_found      (cnt_f),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: which slots hold a test in flight, which hold a passing
  // candidate awaiting delivery, and the result currently on offer.
  logic [N-1:0] m_busy, m_pend, m_tstart;
  logic [W-1:0] m_cand [N];
  logic [W-1:0] m_tcand, m_rdata;
  int           m_rrd, m_rrr, m_rslot;
  bit           m_rv;
  logic [31:0]  m_cd;
  logic [15:0]  m_cf;

  function automatic bit exp_ready(bit r, bit e);
    return !r && e && ((m_busy | m_pend) != {N{1'b1}});
  endfunction

  function automatic bit exp_idle(bit r);
    return r || (((m_busy | m_pend) == '0) && !m_rv);
  endfunction

  task automatic model_clear();
    m_busy = '0; m_pend = '0; m_tstart = '0;
    m_tcand = '0; m_rdata = '0;
    m_rrd = 0; m_rrr = 0; m_rslot = 0; m_rv = 0;
    m_cd = '0; m_cf = '0;
  endtask

  task automatic model_step(input bit r, input bit e, input bit cv, input logic [W-1:0] cd,
                            input logic [N-1:0] dn, input logic [N-1:0] ps, input bit rr);
    logic [N-1:0] pb, pp;
    logic [W-1:0] pc [N];
    bit           hit;
    int           j;
    if (r) begin
      model_clear();
      return;
    end
    pb = m_busy; pp = m_pend;
    for (int i = 0; i < N; i++) pc[i] = m_cand[i];
    m_tstart = '0;
    if (exp_ready(r, e) && cv) begin
      hit = 0;
      for (int k = 0; k < N; k++) begin
        j = (m_rrd + k) % N;
        if (!hit && !pb[j] && !pp[j]) begin
          hit = 1;
          m_busy[j] = 1'b1;
          m_cand[j] = cd;
          m_tstart[j] = 1'b1;
          m_tcand = cd;
          m_rrd = (j + 1) % N;
          m_cd = m_cd + 1;
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (dn[i] && pb[i]) begin
        m_busy[i] = 1'b0;
        if (ps[i]) m_pend[i] = 1'b1;
      end
    if (m_rv) begin
      if (rr) begin
        m_pend[m_rslot] = 1'b0;
        m_rrr = (m_rslot + 1) % N;
        m_cf = m_cf + 1;
        m_rv = 0;
      end
    end else if (pp != '0) begin
      hit = 0;
      for (int k = 0; k < N; k++) begin
        j = (m_rrr + k) % N;
        if (!hit && pp[j]) begin
          hit = 1;
          m_rv = 1;
          m_rslot = j;
          m_rdata = pc[j];
        end
      end
    end
  endtask

  // One clock: drive at the falling edge, compare mid-cycle, advance the model, take the rising edge
  task automatic step(input bit r, input bit e, input bit cv, input logic [W-1:0] cd,
                      input logic [N-1:0] dn, input logic [N-1:0] ps, input bit rr,
                      input bit chk_en);
    @(negedge clk);
    rst = r; en = e;
    bus.cand_valid = cv; bus.cand_data = cd;
    bus.tst_done = dn; bus.tst_pass = ps; bus.res_ready = rr;
    #1;
    if (chk_en) begin
      check("cand_ready", 64'(bus.cand_ready), 64'(exp_ready(r, e)));
      check("idle",       64'(idle),           64'(exp_idle(r)));
      check("tst_start",  64'(bus.tst_start),  64'(m_tstart));
      check("tst_cand",   bus.tst_cand,        m_tcand);
      check("res_valid",  64'(bus.res_valid),  64'(m_rv));
      check("res_data",   bus.res_data,        m_rdata);
      check("cnt_disp",   64'(cnt_d),          64'(m_cd));
      check("cnt_found",  64'(cnt_f),          64'(m_cf));
    end
    model_step(r, e, cv, cd, dn, ps, rr);
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    bus.cand_valid = 1'b0; bus.cand_data = '0;
    bus.tst_done = '0; bus.tst_pass = '0; bus.res_ready = 1'b0;
    model_clear();
    step(1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    step(1, 1, 1, 64'hAA, 4'b1111, 4'b1111, 1, 1);
    #1;
    check("rst_cand_ready", 64'(bus.cand_ready), 64'd0);
    check("rst_idle",       64'(idle),           64'd1);

    // Four consecutive dispatches, then the fifth candidate stalls
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 1, 64'(k + 1), 4'b0000, 4'b0000, 0, 1);
      #1;
      check("seq_start", 64'(bus.tst_start), 64'd1 << k);
    end
    step(0, 1, 1, 64'd5, 4'b0000, 4'b0000, 0, 1);
    #1;
    check("full_ready", 64'(bus.cand_ready), 64'd0);

    // Slot 2 fails, the waiting candidate lands there
    step(0, 1, 1, 64'd5, 4'b0100, 4'b0000, 0, 1);
    #1;
    check("freed_ready", 64'(bus.cand_ready), 64'd1);
    step(0, 1, 1, 64'd5, 4'b0000, 4'b0000, 0, 1);
    #1;
    check("slot2_start", 64'(bus.tst_start), 64'b0100);
    check("slot2_count", 64'(cnt_d),         64'd5);

    // Slots 1 and 3 pass together; delivered in order with a gap between
    step(0, 1, 0, 0, 4'b1010, 4'b1010, 0, 1);
    step(0, 1, 0, 0, 4'b0000, 4'b0000, 0, 1);
    #1;
    check("res1_valid", 64'(bus.res_valid), 64'd1);
    check("res1_data",  bus.res_data,       64'd2);
    step(0, 1, 0, 0, 4'b0000, 4'b0000, 0, 1);
    #1;
    check("res1_hold",  bus.res_data,       64'd2);
    step(0, 1, 0, 0, 4'b0000, 4'b0000, 1, 1);
    #1;
    check("res_gap",    64'(bus.res_valid), 64'd0);
    step(0, 1, 0, 0, 4'b0000, 4'b0000, 0, 1);
    #1;
    check("res2_data",  bus.res_data,       64'd4);
    step(0, 1, 0, 0, 4'b0000, 4'b0000, 1, 1);
    #1;
    check("found_two",  64'(cnt_f),         64'd2);

    // Done on a free slot is ignored
    step(0, 1, 0, 0, 4'b0010, 4'b0010, 0, 1);
    step(0, 1, 0, 0, 4'b0000, 4'b0000, 0, 1);
    #1;
    check("spurious_rv", 64'(bus.res_valid), 64'd0);
    check("spurious_cf", 64'(cnt_f),         64'd2);

    // Disabled: no new starts, running slots still report
    step(0, 0, 1, 64'd9, 4'b0101, 4'b0101, 1, 1);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 1, 64'd9, 4'b0000, 4'b0000, 1, 1);
      #1;
      check("dis_start", 64'(bus.tst_start), 64'd0);
    end
    check("dis_idle",  64'(idle),  64'd1);
    check("dis_found", 64'(cnt_f), 64'd4);

    // Reset with work in flight and a result on offer
    step(0, 1, 1, 64'h77, 4'b0000, 4'b0000, 0, 1);
    step(0, 1, 1, 64'h88, 4'b0000, 4'b0000, 0, 1);
    step(0, 1, 0, 0, 4'b1000, 4'b1000, 0, 1);
    step(0, 1, 0, 0, 4'b0000, 4'b0000, 0, 1);
    #1;
    check("pre_rst_rv", 64'(bus.res_valid), 64'd1);
    step(1, 1, 1, 64'h99, 4'b0000, 4'b0000, 0, 1);
    #1;
    check("mid_rst_rv",   64'(bus.res_valid), 64'd0);
    check("mid_rst_cd",   64'(cnt_d),         64'd0);
    check("mid_rst_cand", bus.tst_cand,       64'd0);
    for (int k = 0; k < 3; k++)
      step(0, 0, 0, 0, 4'b1111, 4'b1111, 1, 1);
    #1;
    check("post_rst_idle", 64'(idle), 64'd1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 9) < 7),
           {$urandom, $urandom},
           {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)},
           4'($urandom),
           ($urandom_range(0, 1) == 1),
           1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
